// File: rtl/med_pkg.sv
// Shared types and defaults for the Manchester encoder/decoder side buffers.
package med_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned DEF_DEPTH   = 16;
  localparam int unsigned DEF_WRN_LOW = 2;
  localparam int unsigned DEF_ACK_TO  = 32;

  typedef logic [BYTE_W-1:0] med_byte_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_ACK
  } med_state_e;

endpackage

// File: rtl/med_tx_fifo_if.sv
// Host push side and encoder wrn/din/tbre handshake of the transmit buffer.
interface med_tx_fifo_if #(
  parameter int unsigned ADDR_W = 4
) ();
  import med_pkg::*;

  logic            host_wr;
  med_byte_t       host_din;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic            ack_err;
  logic            wrn;
  med_byte_t       din;
  logic            tbre;

  modport slave (
    input  host_wr, host_din, tbre,
    output full, empty, count, overflow, ack_err, wrn, din
  );

  modport master (
    output host_wr, host_din, tbre,
    input  full, empty, count, overflow, ack_err, wrn, din
  );

endinterface

// File: rtl/med_sync_fifo.sv
// Generic single-clock FIFO; empty trails count by one cycle so a push is
// seen by the consumer one cycle after it is stored.
module med_sync_fifo import med_pkg::*; #(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned DATA_W = BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data_c,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              push_ok, pop_ok;

  // Pointer/occupancy update; a pop never frees room for a same-cycle push.
  always_comb begin
    push_ok    = push && !full_q;
    pop_ok     = pop && (count_q != '0);
    wptr_d     = wptr_q + ADDR_W'(push_ok);
    rptr_d     = rptr_q + ADDR_W'(pop_ok);
    count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    full_d     = (count_d == CNT_W'(DEPTH));
    empty_d    = (count_q == '0);
    overflow_d = push && full_q;
  end

  // Control state with synchronous reset to empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array, contents irrelevant while empty so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  assign rd_data_c = mem_q[rptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: rtl/med_tx_fifo.sv
// Transmit buffer ahead of the Manchester encoder: queues host bytes and
// strobes them one at a time into the encoder over wrn/din/tbre.
module med_tx_fifo import med_pkg::*; #(
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned ADDR_W  = $clog2(DEPTH),
  parameter int unsigned WRN_LOW = DEF_WRN_LOW,
  parameter int unsigned ACK_TO  = DEF_ACK_TO
) (
  input  logic          clk16x,
  input  logic          rst,
  med_tx_fifo_if.slave  bus
);

  localparam int unsigned ACK_W = $clog2(ACK_TO + 1);

  med_state_e       state_q, state_d;
  logic [2:0]       strb_cnt_q, strb_cnt_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
  med_byte_t        din_q, din_d;
  logic             wrn_q, wrn_d;
  logic             ack_err_q, ack_err_d;
  logic             pop_c;
  logic             fifo_empty;
  med_byte_t        fifo_rd_data;

  med_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (BYTE_W)
  ) u_fifo (
    .clk       (clk16x),
    .rst       (rst),
    .push      (bus.host_wr),
    .wr_data   (bus.host_din),
    .pop       (pop_c),
    .rd_data_c (fifo_rd_data),
    .full      (bus.full),
    .empty     (fifo_empty),
    .count     (bus.count),
    .overflow  (bus.overflow)
  );

  // Handshake sequencing: pop, setup, strobe low, hold, wait for acknowledge.
  always_comb begin
    state_d    = state_q;
    strb_cnt_d = strb_cnt_q;
    ack_cnt_d  = ack_cnt_q;
    din_d      = din_q;
    ack_err_d  = ack_err_q;
    pop_c      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && bus.tbre) begin
          pop_c   = 1'b1;
          din_d   = fifo_rd_data;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        strb_cnt_d = '0;
        state_d    = ST_STROBE;
      end
      ST_STROBE: begin
        if (strb_cnt_q == 3'(WRN_LOW - 1)) begin
          state_d = ST_HOLD;
        end else begin
          strb_cnt_d = strb_cnt_q + 3'd1;
        end
      end
      ST_HOLD: begin
        ack_cnt_d = '0;
        state_d   = ST_ACK;
      end
      ST_ACK: begin
        // A silent encoder is flagged but the byte is not retried.
        if (!bus.tbre) begin
          state_d = ST_IDLE;
        end else if (ack_cnt_q == ACK_W'(ACK_TO - 1)) begin
          ack_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    wrn_d = (state_d != ST_STROBE);
  end

  // State and registered encoder-side outputs.
  always_ff @(posedge clk16x) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      strb_cnt_q <= '0;
      ack_cnt_q  <= '0;
      din_q      <= '0;
      wrn_q      <= 1'b1;
      ack_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      strb_cnt_q <= strb_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
      din_q      <= din_d;
      wrn_q      <= wrn_d;
      ack_err_q  <= ack_err_d;
    end
  end

  assign bus.empty   = fifo_empty;
  assign bus.wrn     = wrn_q;
  assign bus.din     = din_q;
  assign bus.ack_err = ack_err_q;

endmodule
